pipe_add_n: RTL and testbench
=============================

Name: pipe_add_n

Overview:
- Parametrised pipelined N-bit adder/subtractor. Successor to the combinational ripple-carry adder.
- The carry chain is cut into K-bit chunks, with one register stage per chunk. Throughput is one operation per clock at any width.
- Adds a subtract mode, a signed-overflow flag and a valid/ready handshake on both sides.
- Sits between operand sources and accumulate/compare logic in datapaths too wide for a single-cycle ripple.

Parameters:
- N, 16, operand and result width in bits. Must be a multiple of K.
- K, 4, chunk width, i.e. bits resolved per pipeline stage.
- STAGES = N/K is derived, not overridable. It equals the latency in cycles.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand set x/y/carry_in/sub is valid.
- in_ready  output  1  block accepts an operand set this cycle.
- x  input  N  operand A.
- y  input  N  operand B.
- carry_in  input  1  carry into bit 0 (add mode only).
- sub  input  1  0: s = x + y + carry_in. 1: s = x - y.
- out_valid  output  1  s/co/ovf hold a valid result.
- out_ready  input  1  downstream accepts the result this cycle.
- s  output  N  result, modulo 2^N.
- co  output  1  carry out of bit N-1. In sub mode, 1 means no borrow.
- ovf  output  1  two's-complement signed overflow.

Behaviour:
- Effective operand:
  - yb = sub ? ~y : y.
  - c0 = sub ? 1 : carry_in. carry_in is ignored when sub=1.
- Transfer rules:
  - Input transfer: in_valid & in_ready at a rising edge.
  - Output transfer: out_valid & out_ready at a rising edge.
- Global advance: adv = ~out_valid | out_ready.
  - in_ready = adv, combinational.
  - All stages shift one place when adv=1 and hold completely when adv=0.
  - Bubbles are not collapsed.
- Stage j (0..STAGES-1) holds:
  - valid bit.
  - Sum bits [(j+1)K-1:0], already resolved.
  - Carry out of bit (j+1)K-1.
  - Unconsumed upper chunks of x and yb.
  - x[N-1] and yb[N-1], needed for overflow.
- Stage 0 captures chunk 0 of x + yb + c0.
- Stage j adds chunk j of its carried x and yb plus the registered carry from stage j-1.
- Each stage uses one K-bit ripple of full-adder cells. There is no cross-stage combinational carry path.
- Last stage drives s, co, out_valid directly from registers.
  - ovf = (x[N-1] ~^ yb[N-1]) & (s[N-1] ^ x[N-1]), registered in the last stage.
- Latency: an operand set accepted at edge t produces out_valid=1 after edge t+STAGES-1, provided no stall occurs. It transfers at the first edge with out_ready=1.
- Throughput: one operation per cycle with out_ready held high.
- Stall: outputs s/co/ovf/out_valid stay stable while out_valid=1 and out_ready=0.
- Ordering: results emerge in acceptance order. No loss, no duplication.
- Simultaneous output and input transfer in the same cycle is legal and sustains full rate.
- When in_valid=0 with adv=1, a bubble (valid=0) enters stage 0.
- Reset (rst=1 at an edge):
  - All stage valid bits, s, co and ovf go to 0. out_valid=0.
  - in_ready=1 from the cycle after reset.
  - In-flight operations are discarded; none emerge after reset deasserts.
  - Reset has priority over every transfer in the same cycle.
- Degenerate cases:
  - K=N gives STAGES=1, a registered single-cycle adder.
  - K=1 gives a bit-per-stage pipeline.
  - Both must elaborate and pass the same bench.

Test Plan:
- N=16,K=4. add 0x1234+0x4321, cin=0 -> s=0x5555, co=0, ovf=0. out_valid rises exactly 4 edges after acceptance.
- Full ripple: 0xFFFF+0x0000, cin=1 -> s=0x0000, co=1, ovf=0. Also 0x7FFF+0x0001 -> s=0x8000, co=0, ovf=1.
- Subtract: 0x0005-0x0007 -> s=0xFFFE, co=0, ovf=0. 0x8000-0x0001 -> s=0x7FFF, co=1, ovf=1. carry_in=1 has no effect in either case.
- Stream 8 random add/sub ops back-to-back; hold out_ready=0 for 3 cycles mid-stream.
  - in_ready=0 in exactly those cycles.
  - Outputs stay frozen.
  - All 8 results match the reference model in order.
- Assert rst for 1 cycle with 3 ops in flight -> out_valid=0 next cycle, in_ready=1, no stale result appears over the next 10 cycles.
- Parameter sweep: N=4,K=1 and N=4,K=4. 1011+1101, cin=0 -> s=1000, co=1. 1111+0000 -> s=1111, co=0. Latency is 4 and 1 respectively.

Source files
------------

// File: rtl/pipe_add_n.sv
// -----------------------------------------------------------------------------
// pipe_add_n
//   Pipelined N-bit adder/subtractor. The carry chain is split into K-bit
//   chunks, and each chunk is resolved in its own register stage. This gives
//   a throughput of one operation per clock at any width, with a latency of
//   STAGES = N/K cycles. A valid/ready handshake is used on both sides. The
//   whole pipe advances together, or holds together, based on one signal
//   (adv). Bubbles are not collapsed.
//
// Parameters
//   N  operand/result width. Must be a multiple of K.
//   K  bits resolved per pipeline stage.
//
// Ports
//   clk        clock; all state changes on the rising edge
//   rst        synchronous, active-high reset
//   in_valid   operand set (x, y, carry_in, sub) is valid
//   in_ready   block accepts an operand set this cycle (combinational)
//   x, y       operands A and B
//   carry_in   carry into bit 0; ignored when sub=1
//   sub        0: s = x + y + carry_in, 1: s = x - y
//   out_valid  s/co/ovf hold a valid result
//   out_ready  downstream accepts the result this cycle
//   s          result modulo 2^N
//   co         carry out of bit N-1 (in sub mode, 1 means no borrow)
//   ovf        two's-complement signed overflow
// -----------------------------------------------------------------------------
module pipe_add_n #(
    parameter int N = 16,
    parameter int K = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] x,
    input  logic [N-1:0] y,
    input  logic         carry_in,
    input  logic         sub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] s,
    output logic         co,
    output logic         ovf
);

    localparam int STAGES = N / K;

    // One pipeline slot. The x_rem/y_rem fields hold the chunks that have not
    // been consumed yet. They are shifted down by K at each stage, so the next
    // chunk to add is always in bits [K-1:0]. The sign bits travel separately
    // because the overflow term needs them after the operands are used up.
    typedef struct packed {
        logic         valid;
        logic [N-1:0] sum;
        logic         carry;
        logic [N-1:0] x_rem;
        logic [N-1:0] y_rem;
        logic         x_msb;
        logic         yb_msb;
        logic         ovf;
    } stage_t;

    stage_t       stage_q   [STAGES];
    stage_t       stage_d   [STAGES];
    stage_t       stage_src [STAGES];
    logic [N-1:0] yb;
    logic [K:0]   chunk;
    logic         adv;

    // K-bit ripple of full-adder cells. Returns {carry_out, sum}.
    function automatic logic [K:0] ripple(input logic [K-1:0] a,
                                          input logic [K-1:0] b,
                                          input logic         ci);
        logic [K:0]   c;
        logic [K-1:0] r;
        c[0] = ci;
        for (int i = 0; i < K; i++) begin
            r[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
        return {c[K], r};
    endfunction

    // The whole pipe moves only when the output slot is empty or is being
    // drained. Otherwise every stage holds.
    assign adv      = ~out_valid | out_ready;
    assign in_ready = adv;

    always_comb begin
        // NOTE: every variable written here gets a default first. Then no path
        // leaves it unassigned, and no latch is inferred.
        yb        = '0;
        chunk     = '0;
        stage_src = '{default: '0};
        stage_d   = '{default: '0};

        // Subtraction is x + ~y + 1. The "+1" enters as the stage-0 carry.
        yb = sub ? ~y : y;

        stage_src[0].valid  = in_valid;
        stage_src[0].carry  = sub ? 1'b1 : carry_in;
        stage_src[0].x_rem  = x;
        stage_src[0].y_rem  = yb;
        stage_src[0].x_msb  = x[N-1];
        stage_src[0].yb_msb = yb[N-1];
        for (int j = 1; j < STAGES; j++) begin
            stage_src[j] = stage_q[j-1];
        end

        for (int j = 0; j < STAGES; j++) begin
            chunk                = ripple(stage_src[j].x_rem[K-1:0],
                                          stage_src[j].y_rem[K-1:0],
                                          stage_src[j].carry);
            stage_d[j]           = stage_src[j];
            // Bits above j*K are still zero in the incoming sum. OR-ing in
            // the new chunk therefore places it without disturbing lower bits.
            stage_d[j].sum       = stage_src[j].sum | (N'(chunk[K-1:0]) << (j * K));
            stage_d[j].carry     = chunk[K];
            stage_d[j].x_rem     = stage_src[j].x_rem >> K;
            stage_d[j].y_rem     = stage_src[j].y_rem >> K;
            // Overflow happens when both operand signs agree but the result
            // sign differs. This value is only meaningful in the last stage.
            stage_d[j].ovf       = (stage_src[j].x_msb ~^ stage_src[j].yb_msb) &
                                   (stage_d[j].sum[N-1] ^ stage_src[j].x_msb);
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: the whole pipeline array is reset, not just the valid bits.
        // This is needed because s/co/ovf must read 0 after reset, and they
        // come straight from last-stage contents.
        if (rst) begin
            for (int j = 0; j < STAGES; j++) begin
                stage_q[j] <= '0;
            end
        end else if (adv) begin
            // NOTE: sequential state uses non-blocking assignment. All stages
            // then sample the previous-cycle values and shift in lockstep.
            for (int j = 0; j < STAGES; j++) begin
                stage_q[j] <= stage_d[j];
            end
        end
    end

    assign out_valid = stage_q[STAGES-1].valid;
    assign s         = stage_q[STAGES-1].sum;
    assign co        = stage_q[STAGES-1].carry;
    assign ovf       = stage_q[STAGES-1].ovf;

endmodule

// File: tb/tb_pipe_add_n.sv
// -----------------------------------------------------------------------------
// tb_pipe_add_n
//   Directed bench for pipe_add_n. Three instances are built:
//     - the N=16, K=4 default
//     - N=4, K=1 (bit-per-stage)
//     - N=4, K=4 (single registered stage)
//   All expected values are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_pipe_add_n;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    // 16-bit instance
    logic        in_valid, in_ready, carry_in, sub, out_valid, out_ready, co, ovf;
    logic [15:0] x, y, s;

    pipe_add_n #(.N(16), .K(4)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .y         (y),
        .carry_in  (carry_in),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s         (s),
        .co        (co),
        .ovf       (ovf)
    );

    // 4-bit instances share their inputs
    logic       iv4, cin4, sub4, or4;
    logic [3:0] x4, y4;
    logic       k1_in_ready, k1_out_valid, k1_co, k1_ovf;
    logic       kn_in_ready, kn_out_valid, kn_co, kn_ovf;
    logic [3:0] k1_s, kn_s;

    pipe_add_n #(.N(4), .K(1)) u_k1 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (iv4),
        .in_ready  (k1_in_ready),
        .x         (x4),
        .y         (y4),
        .carry_in  (cin4),
        .sub       (sub4),
        .out_valid (k1_out_valid),
        .out_ready (or4),
        .s         (k1_s),
        .co        (k1_co),
        .ovf       (k1_ovf)
    );

    pipe_add_n #(.N(4), .K(4)) u_kn (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (iv4),
        .in_ready  (kn_in_ready),
        .x         (x4),
        .y         (y4),
        .carry_in  (cin4),
        .sub       (sub4),
        .out_valid (kn_out_valid),
        .out_ready (or4),
        .s         (kn_s),
        .co        (kn_co),
        .ovf       (kn_ovf)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // One isolated operation on the 16-bit instance. The check covers the
    // latency (edges counted from the acceptance edge inclusive) and the result.
    task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic ci, input logic sb,
                          input logic [15:0] es, input logic eco, input logic eovf);
        int edges;
        out_ready = 1'b1;
        x = a; y = b; carry_in = ci; sub = sb; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        edges = 1;
        while (!out_valid && edges < 20) begin
            @(posedge clk); #1;
            edges++;
        end
        check({tag, "_lat"}, edges, 4);
        check({tag, "_s"},   s,     es);
        check({tag, "_co"},  co,    eco);
        check({tag, "_ovf"}, ovf,   eovf);
        @(posedge clk); #1;
    endtask

    // One operation applied to both 4-bit instances at the same time.
    task automatic run_small(input string tag, input logic [3:0] a, input logic [3:0] b,
                             input logic ci, input logic sb,
                             input logic [3:0] es, input logic eco, input logic eovf);
        int         lat1;
        int         latn;
        logic [5:0] r1;
        logic [5:0] rn;
        lat1 = -1; latn = -1; r1 = '0; rn = '0;
        or4 = 1'b1;
        x4 = a; y4 = b; cin4 = ci; sub4 = sb; iv4 = 1'b1;
        @(posedge clk); #1;
        iv4 = 1'b0;
        for (int e = 1; e <= 12; e++) begin
            if (lat1 < 0 && k1_out_valid) begin lat1 = e; r1 = {k1_s, k1_co, k1_ovf}; end
            if (latn < 0 && kn_out_valid) begin latn = e; rn = {kn_s, kn_co, kn_ovf}; end
            if (lat1 >= 0 && latn >= 0) break;
            @(posedge clk); #1;
        end
        check({tag, "_k1_lat"}, lat1, 4);
        check({tag, "_k1_res"}, r1, {es, eco, eovf});
        check({tag, "_kn_lat"}, latn, 1);
        check({tag, "_kn_res"}, rn, {es, eco, eovf});
        repeat (2) @(posedge clk);
        #1;
    endtask

    // Stream vectors: x, y, carry_in, sub -> s, co, ovf (hand-computed)
    logic [15:0] st_x   [8] = '{16'h0001, 16'h1000, 16'hFFFF, 16'h0000,
                                16'h4000, 16'h7FFF, 16'hABCD, 16'h0100};
    logic [15:0] st_y   [8] = '{16'h0002, 16'h0001, 16'hFFFF, 16'h0000,
                                16'h4000, 16'hFFFF, 16'h1111, 16'h0200};
    logic        st_ci  [8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic        st_sb  [8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [15:0] st_s   [8] = '{16'h0003, 16'h0FFF, 16'hFFFF, 16'h0000,
                                16'h8000, 16'h8000, 16'hBCDF, 16'hFF00};
    logic        st_co  [8] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic        st_ovf [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int  idx;
        int  oidx;
        bit  stall;
        bit  do_in;
        bit  do_out;

        rst = 1'b1;
        in_valid = 1'b0; x = '0; y = '0; carry_in = 1'b0; sub = 1'b0; out_ready = 1'b1;
        iv4 = 1'b0; x4 = '0; y4 = '0; cin4 = 1'b0; sub4 = 1'b0; or4 = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid",    out_valid,    0);
        check("rst_s",            {co, ovf, s}, 0);
        check("rst_k1_out_valid", k1_out_valid, 0);
        check("rst_kn_out_valid", kn_out_valid, 0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("post_rst_in_ready", {in_ready, k1_in_ready, kn_in_ready}, 3'b111);

        // Directed single operations
        run_op("add_basic",  16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0);
        run_op("add_ripple", 16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
        run_op("add_ovf",    16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        run_op("sub_neg",    16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        run_op("sub_neg_c",  16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        run_op("sub_ovf",    16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
        run_op("sub_ovf_c",  16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1);

        // Back-to-back stream with out_ready low in cycles 6..8
        idx = 0; oidx = 0;
        for (int cyc = 0; cyc < 40 && oidx < 8; cyc++) begin
            stall     = (cyc >= 6 && cyc <= 8);
            out_ready = !stall;
            if (idx < 8) begin
                x = st_x[idx]; y = st_y[idx]; carry_in = st_ci[idx]; sub = st_sb[idx];
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            check("stream_in_ready", in_ready, stall ? 0 : 1);
            if (stall) begin
                check("stall_out_valid", out_valid, 1);
                check("stall_frozen", {co, ovf, s}, {st_co[oidx], st_ovf[oidx], st_s[oidx]});
            end
            do_in  = in_valid && in_ready;
            do_out = out_valid && out_ready;
            if (do_out) begin
                check("stream_res", {co, ovf, s}, {st_co[oidx], st_ovf[oidx], st_s[oidx]});
            end
            @(posedge clk); #1;
            if (do_in)  idx++;
            if (do_out) oidx++;
        end
        check("stream_count", oidx, 8);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check("stream_no_extra", out_valid, 0);

        // Reset with three operations in flight (plus one offered during reset)
        for (int i = 0; i < 3; i++) begin
            x = 16'h1111 << i; y = 16'h0001; carry_in = 1'b0; sub = 1'b0; in_valid = 1'b1;
            @(posedge clk); #1;
        end
        rst = 1'b1;
        x = 16'h2222;
        @(posedge clk); #1;
        rst = 1'b0;
        in_valid = 1'b0;
        check("rst_flight_out_valid", out_valid, 0);
        check("rst_flight_in_ready",  in_ready,  1);
        check("rst_flight_res",       {co, ovf, s}, 0);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check("rst_no_stale", out_valid, 0);
        end

        // Degenerate parameterisations
        run_small("sw_add",  4'b1011, 4'b1101, 1'b0, 1'b0, 4'b1000, 1'b1, 1'b0);
        run_small("sw_pass", 4'b1111, 4'b0000, 1'b0, 1'b0, 4'b1111, 1'b0, 1'b0);
        run_small("sw_ovf",  4'b0111, 4'b0001, 1'b0, 1'b0, 4'b1000, 1'b0, 1'b1);
        run_small("sw_sub",  4'b0011, 4'b0101, 1'b1, 1'b1, 4'b1110, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
